// File: rtl/cpu_run_controller_pkg.sv
// Shared encodings for the CPU run controller: command opcodes, run states and widths.
package cpu_run_controller_pkg;

    localparam int unsigned OPCODE_WIDTH  = 3;
    localparam int unsigned STATE_WIDTH   = 2;
    localparam int unsigned ADDR_WIDTH    = 32;
    localparam int unsigned RST_CNT_WIDTH = 8;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP    = 3'd0,
        OP_HALT   = 3'd1,
        OP_RESUME = 3'd2,
        OP_STEP   = 3'd3,
        OP_RESET  = 3'd4,
        OP_SET_BP = 3'd5,
        OP_CLR_BP = 3'd6,
        OP_RSVD   = 3'd7
    } opcode_e;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_RUN       = 2'd0,
        ST_HALTED    = 2'd1,
        ST_STEP      = 2'd2,
        ST_RESETTING = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_run_controller.sv
// Debug run controller: halts, resumes, single-steps and resets the core, with one
// instruction breakpoint that stalls a matching fetch before it issues.
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned STEP_WIDTH   = 16
) (
    input  logic                    i_Clock,
    input  logic                    w_Reset,
    input  logic                    i_Cmd_Valid,
    input  logic [OPCODE_WIDTH-1:0] i_Cmd_Opcode,
    input  logic [ADDR_WIDTH-1:0]   i_Cmd_Arg,
    output logic                    o_Cmd_Ready,
    input  logic [ADDR_WIDTH-1:0]   i_PC,
    input  logic                    i_Instruction_Valid,
    input  logic                    i_Retire,
    output logic                    o_Halt_Cpu,
    output logic                    o_Reset_Cpu,
    output logic [STATE_WIDTH-1:0]  o_State,
    output logic                    o_Bp_Hit,
    output logic                    o_Cmd_Error
);

    state_e                   state, state_n;
    logic [STEP_WIDTH-1:0]    step_cnt, step_cnt_n;
    logic [RST_CNT_WIDTH-1:0] rst_cnt, rst_cnt_n;
    logic [ADDR_WIDTH-1:0]    bp_addr, bp_addr_n;
    logic                     bp_en, bp_en_n;
    logic                     skip, skip_n;
    logic                     halt_q, halt_n;
    logic                     reset_cpu_n, ready_n, cmd_err_n;

    opcode_e               op;
    logic                  cmd_fire;
    logic                  bp_match_c;
    logic [STEP_WIDTH-1:0] step_arg;
    logic                  step_arg_nz;

    assign op          = opcode_e'(i_Cmd_Opcode);
    assign cmd_fire    = i_Cmd_Valid && (state != ST_RESETTING);
    assign step_arg    = i_Cmd_Arg[STEP_WIDTH-1:0];
    assign step_arg_nz = (step_arg != '0);
    assign bp_match_c  = bp_en && i_Instruction_Valid && (i_PC == bp_addr)
                         && ((state == ST_RUN) || (state == ST_STEP)) && !skip;

    // Breakpoint match stalls the fetch in the same cycle it is presented.
    assign o_Halt_Cpu = halt_q || bp_match_c;
    assign o_State    = state;

    always_ff @(posedge i_Clock) begin
        if (w_Reset) begin
            state       <= ST_RUN;
            step_cnt    <= '0;
            rst_cnt     <= '0;
            bp_addr     <= '0;
            bp_en       <= 1'b0;
            skip        <= 1'b0;
            halt_q      <= 1'b0;
            o_Reset_Cpu <= 1'b0;
            o_Cmd_Ready <= 1'b1;
            o_Bp_Hit    <= 1'b0;
            o_Cmd_Error <= 1'b0;
        end else begin
            state       <= state_n;
            step_cnt    <= step_cnt_n;
            rst_cnt     <= rst_cnt_n;
            bp_addr     <= bp_addr_n;
            bp_en       <= bp_en_n;
            skip        <= skip_n;
            halt_q      <= halt_n;
            o_Reset_Cpu <= reset_cpu_n;
            o_Cmd_Ready <= ready_n;
            o_Bp_Hit    <= bp_match_c;
            o_Cmd_Error <= cmd_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        step_cnt_n = step_cnt;
        rst_cnt_n  = rst_cnt;
        bp_addr_n  = bp_addr;
        bp_en_n    = bp_en;
        skip_n     = skip;
        cmd_err_n  = 1'b0;

        // Skip lets a resumed core leave the breakpoint address without re-trapping.
        if (i_Instruction_Valid && (i_PC != bp_addr)) begin
            skip_n = 1'b0;
        end

        unique case (state)
            ST_RUN: begin
                if (cmd_fire) begin
                    if (op == OP_HALT) begin
                        state_n = ST_HALTED;
                    end else if (op == OP_STEP && step_arg_nz) begin
                        state_n    = ST_STEP;
                        step_cnt_n = step_arg;
                    end else if (op == OP_RESET) begin
                        state_n   = ST_RESETTING;
                        rst_cnt_n = RST_CNT_WIDTH'(RESET_CYCLES - 1);
                    end
                end
            end
            ST_HALTED: begin
                if (cmd_fire) begin
                    if (op == OP_RESUME) begin
                        state_n = ST_RUN;
                        skip_n  = 1'b1;
                    end else if (op == OP_STEP) begin
                        skip_n = 1'b1;
                        if (step_arg_nz) begin
                            state_n    = ST_STEP;
                            step_cnt_n = step_arg;
                        end
                    end else if (op == OP_RESET) begin
                        state_n   = ST_RESETTING;
                        rst_cnt_n = RST_CNT_WIDTH'(RESET_CYCLES - 1);
                    end
                end
            end
            ST_STEP: begin
                if (i_Retire && (step_cnt != '0)) begin
                    step_cnt_n = step_cnt - STEP_WIDTH'(1);
                    if (step_cnt == STEP_WIDTH'(1)) begin
                        state_n = ST_HALTED;
                    end
                end
                // Commands override the retire outcome; HALT lands in HALTED either way.
                if (cmd_fire) begin
                    if (op == OP_HALT) begin
                        state_n = ST_HALTED;
                    end else if (op == OP_RESUME) begin
                        state_n = ST_RUN;
                    end else if (op == OP_RESET) begin
                        state_n   = ST_RESETTING;
                        rst_cnt_n = RST_CNT_WIDTH'(RESET_CYCLES - 1);
                    end else if (op == OP_STEP && step_arg_nz) begin
                        state_n    = ST_STEP;
                        step_cnt_n = step_arg;
                    end
                end
            end
            ST_RESETTING: begin
                if (rst_cnt == '0) begin
                    state_n = ST_HALTED;
                end else begin
                    rst_cnt_n = rst_cnt - RST_CNT_WIDTH'(1);
                end
            end
            default: state_n = ST_RUN;
        endcase

        if (cmd_fire) begin
            if (op == OP_SET_BP) begin
                bp_addr_n = i_Cmd_Arg;
                bp_en_n   = 1'b1;
            end else if (op == OP_CLR_BP) begin
                bp_en_n = 1'b0;
            end else if (op == OP_RSVD) begin
                cmd_err_n = 1'b1;
            end
        end

        if (bp_match_c) begin
            state_n = ST_HALTED;
        end

        halt_n      = (state_n == ST_HALTED) || (state_n == ST_RESETTING);
        reset_cpu_n = (state_n == ST_RESETTING);
        ready_n     = (state_n != ST_RESETTING);
    end

endmodule
